// File: rtl/imem_fetch_sequencer.sv
// Shares one byte-wide, little-endian instruction memory port between the CPU
// fetch path (4-byte instruction assembly) and a program-loader write path.
module imem_fetch_sequencer #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned MEM_BYTES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_fault,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_wdata,
    output logic              load_ack,
    output logic              load_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE, WRITE} state_t;

    // base+3 >= MEM_BYTES rewritten as base >= MEM_BYTES-3 so the check never wraps
    localparam logic [ADDR_W-1:0] FETCH_LIMIT = ADDR_W'(MEM_BYTES - 3);
    localparam logic [ADDR_W-1:0] LOAD_LIMIT  = ADDR_W'(MEM_BYTES);

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       instr_q, instr_d;
    logic              fault_q, fault_d;
    logic              prio_load_q, prio_load_d;
    logic              lderr_q, lderr_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_we_d;
    logic [7:0]        mem_wdata_d;

    logic grant_fetch;
    logic grant_load;
    logic fetch_bad;
    logic load_ok;

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            base_q      <= '0;
            instr_q     <= '0;
            fault_q     <= 1'b0;
            prio_load_q <= 1'b1;
            lderr_q     <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            instr_q     <= instr_d;
            fault_q     <= fault_d;
            prio_load_q <= prio_load_d;
            lderr_q     <= lderr_d;
            mem_addr    <= mem_addr_d;
            mem_we      <= mem_we_d;
            mem_wdata   <= mem_wdata_d;
        end
    end

    // Arbitration, next-state and next-register values; status outputs decoded from state
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        instr_d     = instr_q;
        fault_d     = fault_q;
        prio_load_d = prio_load_q;
        lderr_d     = lderr_q;
        mem_addr_d  = mem_addr;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata;

        grant_fetch = (state_q == IDLE) && fetch_req && (!load_req || !prio_load_q);
        grant_load  = (state_q == IDLE) && load_req  && (!fetch_req || prio_load_q);
        fetch_bad   = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= FETCH_LIMIT);
        load_ok     = (load_addr < LOAD_LIMIT);

        case (state_q)
            IDLE: begin
                if (grant_fetch) begin
                    base_d      = fetch_addr;
                    instr_d     = '0;
                    fault_d     = fetch_bad;
                    prio_load_d = 1'b1;
                    if (fetch_bad) begin
                        state_d = DONE;
                    end else begin
                        mem_addr_d = fetch_addr;
                        beat_d     = '0;
                        state_d    = FETCH;
                    end
                end else if (grant_load) begin
                    prio_load_d = 1'b0;
                    lderr_d     = !load_ok;
                    state_d     = WRITE;
                    if (load_ok) begin
                        mem_addr_d  = load_addr;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = load_wdata;
                    end
                end
            end
            FETCH: begin
                case (beat_q)
                    2'd0:    instr_d[7:0]   = mem_rdata;
                    2'd1:    instr_d[15:8]  = mem_rdata;
                    2'd2:    instr_d[23:16] = mem_rdata;
                    default: instr_d[31:24] = mem_rdata;
                endcase
                mem_addr_d = base_q + ADDR_W'(beat_q) + ADDR_W'(1);
                beat_d     = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        fetch_ready = grant_fetch;
        fetch_valid = (state_q == DONE);
        fetch_fault = (state_q == DONE) && fault_q;
        fetch_instr = ((state_q == DONE) && !fault_q) ? instr_q : '0;
        load_ack    = (state_q == WRITE);
        load_err    = (state_q == WRITE) && lderr_q;
    end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer with a 16-byte async-read memory attached.
module tb_imem_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        load_req;
    logic [63:0] load_addr;
    logic [7:0]  load_wdata;
    logic        load_ack;
    logic        load_err;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [16];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    imem_fetch_sequencer #(.ADDR_W(64), .MEM_BYTES(16)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
        .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_ack(load_ack), .load_err(load_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: async read, synchronous write
    assign mem_rdata = (mem_addr < 64'd16) ? mem[mem_addr[3:0]] : 8'h00;
    always @(posedge clk) begin
        if (mem_we && mem_addr < 64'd16) mem[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({fetch_ready, fetch_valid, fetch_instr, fetch_fault, load_ack, load_err,
             mem_addr, mem_we, mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b valid=%b instr=%h fault=%b ack=%b err=%b addr=%h we=%b wdata=%h, want all 0",
                     fetch_ready, fetch_valid, fetch_instr, fetch_fault, load_ack, load_err,
                     mem_addr, mem_we, mem_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Issues one fetch, checks acceptance, latency, instruction and fault flag
    task automatic do_fetch(input string name, input logic [63:0] addr,
                            input logic [31:0] exp_instr, input logic exp_fault,
                            input int exp_lat, output int acc_cyc);
        int lat;
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        @(negedge clk);
        acc_cyc = cyc;
        n_cmp++;
        if (fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ready: got %b want 1", name, fetch_ready);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (fetch_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (fetch_instr !== exp_instr || fetch_fault !== exp_fault) begin
            n_err++;
            $display("FAIL %s_data: got instr=%h fault=%b want instr=%h fault=%b",
                     name, fetch_instr, fetch_fault, exp_instr, exp_fault);
        end
    endtask

    task automatic test_fetch_single();
        int a;
        do_fetch("fetch0", 64'd0, 32'h02853483, 1'b0, 5, a);
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        do_fetch("fetch4",  64'd4,  32'h009A84B3, 1'b0, 5, a0);
        do_fetch("fetch8",  64'd8,  32'h00148493, 1'b0, 5, a1);
        do_fetch("fetch12", 64'd12, 32'h02953423, 1'b0, 5, a2);
        n_cmp++;
        if (a1 - a0 != 6 || a2 - a1 != 6) begin
            n_err++;
            $display("FAIL b2b_pitch: got %0d,%0d want 6,6", a1 - a0, a2 - a1);
        end
    endtask

    task automatic test_fault();
        int a;
        logic [63:0] prev;
        prev = mem_addr;
        do_fetch("fault_misalign", 64'd2, 32'h0, 1'b1, 1, a);
        n_cmp++;
        if (mem_addr !== prev) begin
            n_err++;
            $display("FAIL fault_misalign_noread: mem_addr got %h want %h", mem_addr, prev);
        end
        do_fetch("fault_range", 64'd16, 32'h0, 1'b1, 1, a);
        n_cmp++;
        if (mem_addr !== prev) begin
            n_err++;
            $display("FAIL fault_range_noread: mem_addr got %h want %h", mem_addr, prev);
        end
        do_fetch("fault_wrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 1'b1, 1, a);
    endtask

    task automatic test_arbitration();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        load_req   = 1'b1;
        load_addr  = 64'd0;
        load_wdata = 8'hFF;
        fetch_req  = 1'b1;
        fetch_addr = 64'd0;
        @(negedge clk);
        n_cmp++;
        if (fetch_ready !== 1'b0) begin
            n_err++;
            $display("FAIL arb_loader_first: fetch_ready got %b want 0", fetch_ready);
        end
        @(posedge clk); #1;
        load_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (load_ack !== 1'b1 || load_err !== 1'b0 || mem_we !== 1'b1 ||
            mem_addr !== 64'd0 || mem_wdata !== 8'hFF || fetch_ready !== 1'b0) begin
            n_err++;
            $display("FAIL arb_write: got ack=%b err=%b we=%b addr=%h wdata=%h ready=%b want 1 0 1 0 ff 0",
                     load_ack, load_err, mem_we, mem_addr, mem_wdata, fetch_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (fetch_ready !== 1'b1 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL arb_fetch_next: got ready=%b we=%b want 1 0", fetch_ready, mem_we);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (fetch_valid === 1'b1) break;
        end
        n_cmp++;
        if (fetch_valid !== 1'b1 || fetch_instr !== 32'h028534FF || fetch_fault !== 1'b0) begin
            n_err++;
            $display("FAIL arb_fetch_data: got valid=%b instr=%h fault=%b want 1 028534ff 0",
                     fetch_valid, fetch_instr, fetch_fault);
        end
    endtask

    task automatic do_load(input string name, input logic [63:0] addr,
                           input logic [7:0] data, input logic exp_err);
        @(posedge clk); #1;
        load_req   = 1'b1;
        load_addr  = addr;
        load_wdata = data;
        @(posedge clk); #1;
        load_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (load_ack !== 1'b1 || load_err !== exp_err || mem_we !== !exp_err) begin
            n_err++;
            $display("FAIL %s_ack: got ack=%b err=%b we=%b want ack=1 err=%b we=%b",
                     name, load_ack, load_err, mem_we, exp_err, !exp_err);
        end
        if (!exp_err) begin
            n_cmp++;
            if (mem_addr !== addr || mem_wdata !== data) begin
                n_err++;
                $display("FAIL %s_port: got addr=%h wdata=%h want addr=%h wdata=%h",
                         name, mem_addr, mem_wdata, addr, data);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b0 || load_ack !== 1'b0) begin
            n_err++;
            $display("FAIL %s_single: got we=%b ack=%b want 0 0", name, mem_we, load_ack);
        end
    endtask

    task automatic test_load();
        do_load("load_err20", 64'd20, 8'hAA, 1'b1);
        do_load("load_err16", 64'd16, 8'h55, 1'b1);
        do_load("load_ok15",  64'd15, 8'h02, 1'b0);
    endtask

    task automatic test_reset_abort();
        int a;
        int seen;
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = 64'd8;
        @(negedge clk);
        n_cmp++;
        if (fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_ready: got %b want 1", fetch_ready);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({fetch_valid, fetch_instr, fetch_fault, load_ack, mem_addr, mem_we, mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got valid=%b instr=%h fault=%b ack=%b addr=%h we=%b wdata=%h want all 0",
                     fetch_valid, fetch_instr, fetch_fault, load_ack, mem_addr, mem_we, mem_wdata);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (fetch_valid === 1'b1 || load_ack === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_no_pulse: got %0d pulses want 0", seen);
        end
        do_fetch("abort_refetch", 64'd4, 32'h009A84B3, 1'b0, 5, a);
    endtask

    initial begin
        logic [7:0] init_bytes [16] = '{8'h83, 8'h34, 8'h85, 8'h02, 8'hB3, 8'h84, 8'h9A, 8'h00,
                                        8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h34, 8'h95, 8'h02};
        for (int i = 0; i < 16; i++) mem[i] = init_bytes[i];
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_req   = 1'b0;
        load_addr  = '0;
        load_wdata = '0;

        test_reset();
        test_fetch_single();
        test_back_to_back();
        test_fault();
        test_arbitration();
        test_load();
        test_reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
